// File: rtl/rv_prefetch_pkg.sv
// Shared constants and helpers for the instruction prefetch unit.
// No logic of its own; pure compile-time definitions.
// Entry layout is {pc, inst, fault}, fault in bit 0.
package rv_prefetch_pkg;

  // Size of one instruction word in bytes; sequential fetch stride.
  localparam int unsigned ISA_INST_SIZE = 4;

  // Architectural reset vector: first fetch address out of reset.
  localparam logic [31:0] ISA_RVEC = 32'h0000_0080;

  // Width of one queue entry {pc, inst, fault} for a given XLEN.
  function automatic int unsigned entry_width(input int unsigned xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/rv_prefetch_sync_fifo.sv
// Generic synchronous FIFO with synchronous clear, head data shown directly.
// Latency: a pushed word is visible at data_o the cycle after the push.
// Backpressure: push when full and pop when empty are ignored; callers track count_o.
module rv_prefetch_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push_i && (cnt_q != CW'(Depth));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Pointer and occupancy bookkeeping; clear acts like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rv_prefetch.sv
// Instruction prefetch queue with multiple in-flight fetches and epoch-style flush (RV_PREFETCH_BYPASS_EN adds same-cycle bypass).
// Latency: response visible on inst_* one cycle after fetch_rvalid (zero cycles via bypass when queue empty).
// Backpressure: fetch_req is credit-gated on queue occupancy plus in-flight count; inst_ready pops the head.
module rv_prefetch
  import rv_prefetch_pkg::*;
#(
  parameter int unsigned     Width          = 32,
  parameter int unsigned     Depth          = 4,
  parameter int unsigned     MaxOutstanding = 2,
  parameter logic [Width-1:0] ResetValue    = Width'(ISA_RVEC)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fetch_req,
  output logic [Width-1:0] fetch_addr,
  input  logic             fetch_gnt,
  input  logic             fetch_rvalid,
  input  logic [Width-1:0] fetch_rdata,
  input  logic             fetch_fault,
  output logic             inst_valid,
  output logic [Width-1:0] inst,
  output logic [Width-1:0] inst_pc,
  output logic             inst_fault,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [Width-1:0] redirect_pc,
  input  logic             halt
);

  localparam int unsigned EntryW = entry_width(Width);
  localparam int unsigned QCntW  = $clog2(Depth) + 1;
  localparam int unsigned PCntW  = $clog2(MaxOutstanding) + 1;
  localparam int unsigned SumW   = QCntW + 1;

  logic [Width-1:0]  fetch_addr_q, fetch_addr_d;
  logic [PCntW-1:0]  drop_q, drop_d;
  logic              stop_q, stop_d;

  logic [QCntW-1:0]  q_cnt;
  logic [PCntW-1:0]  pc_cnt;
  logic [EntryW-1:0] q_head, q_wdata;
  logic [Width-1:0]  pc_head;
  logic [SumW-1:0]   outstanding;
  logic              q_empty, q_push, q_pop;
  logic              grant, rsp_live, rsp_stale, byp_vld;

  // In-flight requests = live ones (PC FIFO) + stale ones awaiting discard.
  assign outstanding = SumW'(pc_cnt) + SumW'(drop_q);
  assign q_empty     = (q_cnt == '0);

  // Credit check: never issue more than the queue could absorb.
  always_comb begin
    fetch_req = rst_n && !redirect && !halt && !stop_q
             && ((SumW'(q_cnt) + outstanding) < SumW'(Depth))
             && (outstanding < SumW'(MaxOutstanding));
  end

  assign fetch_addr = fetch_addr_q;
  assign grant      = fetch_req && fetch_gnt;
  // A response during a redirect belongs to the old stream and is dropped.
  assign rsp_stale  = fetch_rvalid && (drop_q != '0);
  assign rsp_live   = fetch_rvalid && (drop_q == '0) && !redirect;

`ifdef RV_PREFETCH_BYPASS_EN
  assign byp_vld = q_empty && rsp_live;
`else
  assign byp_vld = 1'b0;
`endif

  // A bypassed entry that is consumed immediately never enters the queue.
  assign q_push  = rsp_live && !(byp_vld && inst_ready);
  assign q_pop   = !q_empty && inst_ready && !redirect;
  assign q_wdata = {pc_head, fetch_rdata, fetch_fault};

  rv_prefetch_sync_fifo #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_inst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (q_push),
    .data_i  (q_wdata),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .count_o (q_cnt)
  );

  rv_prefetch_sync_fifo #(
    .Width (Width),
    .Depth (MaxOutstanding)
  ) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (grant),
    .data_i  (fetch_addr_q),
    .pop_i   (rsp_live),
    .data_o  (pc_head),
    .count_o (pc_cnt)
  );

  // Head presentation: queue head first, otherwise the bypassed response; zero when idle.
  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    inst_fault = 1'b0;
    if (!q_empty) begin
      inst_valid = 1'b1;
      inst_pc    = q_head[2*Width:Width+1];
      inst       = q_head[Width:1];
      inst_fault = q_head[0];
    end else if (byp_vld) begin
      inst_valid = 1'b1;
      inst_pc    = pc_head;
      inst       = fetch_rdata;
      inst_fault = fetch_fault;
    end
  end

  // Next-state for fetch address, stale-response counter and fault stop.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    stop_d       = stop_q;
    if (grant) fetch_addr_d = fetch_addr_q + Width'(ISA_INST_SIZE);
    if (rsp_stale) drop_d = drop_q - PCntW'(1);
    if (rsp_live && fetch_fault) stop_d = 1'b1;
    if (redirect) begin
      fetch_addr_d = redirect_pc & ~Width'(3);
      // Everything still in flight, minus a response landing now, is stale.
      drop_d       = PCntW'(outstanding - SumW'(fetch_rvalid));
      stop_d       = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr_q <= ResetValue;
      drop_q       <= '0;
      stop_q       <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      stop_q       <= stop_d;
    end
  end

endmodule

// File: tb/tb_rv_prefetch.sv
module tb_rv_prefetch;
  import rv_prefetch_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam int M = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, fetch_req, fetch_gnt, fetch_rvalid, fetch_fault;
  logic          inst_valid, inst_fault, inst_ready, redirect, halt;
  logic [W-1:0]  fetch_addr, fetch_rdata, inst, inst_pc, redirect_pc;

  rv_prefetch #(
    .Width          (W),
    .Depth          (D),
    .MaxOutstanding (M),
    .ResetValue     (ISA_RVEC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_fault  (fetch_fault),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_fault   (inst_fault),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt)
  );

  // One fetched word as the model sees it; live=0 marks a flushed request.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
    logic        flt;
    logic        live;
  } txn_t;

  txn_t        inflight[$];   // granted, not yet answered (bus order)
  txn_t        q[$];          // expected instruction queue contents
  logic [31:0] nxt_pc;
  bit          stop;

  int n_chk = 0;
  int n_pass = 0;
  int gnt_pct, rsp_pct, rdy_pct, redir_pct, halt_pct, flt_pct;
  int grants, pops;
  bit          use_fixed;
  logic [31:0] fixed_rpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    inflight.delete();
    q.delete();
    nxt_pc = ISA_RVEC;
    stop   = 1'b0;
  endtask

  // Drive one cycle of random stimulus, check outputs, then advance the model.
  task automatic cycle(input bit do_rst);
    bit   exp_req, byp, was_empty, live_now, fire, pop_now;
    txn_t h0, e;
    h0 = (inflight.size() > 0) ? inflight[0] : '0;
    rst_n        = !do_rst;
    redirect     = !do_rst && ($urandom_range(0, 99) < redir_pct);
    redirect_pc  = use_fixed ? fixed_rpc : 32'($urandom_range(0, 4095));
    halt         = ($urandom_range(0, 99) < halt_pct);
    inst_ready   = ($urandom_range(0, 99) < rdy_pct);
    fetch_gnt    = ($urandom_range(0, 99) < gnt_pct);
    fetch_rvalid = !do_rst && (inflight.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
    fetch_rdata  = fetch_rvalid ? h0.dat : $urandom;
    fetch_fault  = fetch_rvalid ? h0.flt : 1'b0;
    #1;
    exp_req   = !redirect && !halt && !stop
             && (q.size() + inflight.size() < D) && (inflight.size() < M);
    live_now  = fetch_rvalid && h0.live && !redirect;
    was_empty = (q.size() == 0);
    byp       = 1'b0;
`ifdef RV_PREFETCH_BYPASS_EN
    byp = was_empty && live_now;
`endif
    if (!do_rst) begin
      chk("fetch_req", {31'd0, fetch_req}, {31'd0, exp_req});
      if (exp_req) chk("fetch_addr", fetch_addr, nxt_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, (!was_empty || byp)});
      if (!was_empty || byp) begin
        e = was_empty ? h0 : q[0];
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.dat);
        chk("inst_fault", {31'd0, inst_fault}, {31'd0, e.flt});
      end
      if (inst_valid && inst_ready && !redirect) pops++;
    end
    fire    = !do_rst && exp_req && fetch_gnt;
    pop_now = !do_rst && !redirect && inst_ready && !was_empty;
    @(posedge clk);
    #1;
    if (do_rst) begin
      model_reset();
    end else begin
      if (fetch_rvalid) begin
        void'(inflight.pop_front());
        if (live_now && !(byp && inst_ready)) q.push_back(h0);
        if (live_now && h0.flt) stop = 1'b1;
      end
      if (pop_now) q.delete(0);
      if (fire) begin
        inflight.push_back('{pc: nxt_pc, dat: $urandom,
                             flt: ($urandom_range(0, 99) < flt_pct), live: 1'b1});
        nxt_pc = nxt_pc + 32'(ISA_INST_SIZE);
        grants++;
      end
      if (redirect) begin
        q.delete();
        foreach (inflight[i]) inflight[i].live = 1'b0;
        nxt_pc = redirect_pc & ~32'h3;
        stop   = 1'b0;
      end
    end
  endtask

  task automatic set_mode(input int g, input int r, input int rd, input int rx,
                          input int h, input int f);
    gnt_pct = g; rsp_pct = r; rdy_pct = rd; redir_pct = rx; halt_pct = h; flt_pct = f;
  endtask

  initial begin
    rst_n = 1'b0; fetch_gnt = 1'b0; fetch_rvalid = 1'b0; fetch_rdata = '0;
    fetch_fault = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    halt = 1'b0; use_fixed = 1'b0; fixed_rpc = '0; grants = 0; pops = 0;
    model_reset();

    // Reset state
    set_mode(100, 100, 100, 0, 0, 0);
    repeat (3) cycle(1'b1);
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_fetch_addr", fetch_addr, ISA_RVEC);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_fault", {31'd0, inst_fault}, 32'd0);

    // Streaming: single-cycle grant and response, consumer always ready
    repeat (20) cycle(1'b0);
    pops = 0;
    repeat (20) cycle(1'b0);
    chk("throughput", 32'(pops), 32'd20);

    // Redirect to 0x100 with fetches in flight, then fill with consumer stalled
    use_fixed = 1'b1; fixed_rpc = 32'h100;
    set_mode(100, 100, 0, 100, 0, 0);
    cycle(1'b0);
    set_mode(100, 100, 0, 0, 0, 0);
    grants = 0;
    repeat (20) cycle(1'b0);
    chk("fill_grants", 32'(grants), 32'(D));
    chk("fill_req_low", {31'd0, fetch_req}, 32'd0);
    chk("fill_head_pc", inst_pc, 32'h100);
    use_fixed = 1'b0;

    // Random traffic: redirects, halts, faults, bursty bus
    set_mode(70, 60, 60, 4, 15, 5);
    repeat (2500) cycle(1'b0);

    // Reset mid-operation; bus drops its in-flight responses
    repeat (2) cycle(1'b1);
    chk("midrst_fetch_addr", fetch_addr, ISA_RVEC);
    chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    set_mode(80, 70, 70, 3, 10, 4);
    repeat (800) cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
